// File: rtl/digital_countdown_timer.sv
// rtl/digital_countdown_timer.sv - programmable min/sec/ms countdown timer with alarm
//
// Purpose: loads a clamped min/sec/ms preset and counts it down to 00:00.000,
// one millisecond step every TICK_DIV enabled cycles, then pulses done and
// raises a sticky alarm until ack or load.
//
// Ports:
//   clk                      rising-edge system clock
//   reset                    synchronous active-low reset
//   load                     capture set_* (clamped) into count/preset; ignored in RUN
//   set_min/set_sec/set_ms   preset value (6/6/10 bits)
//   start, pause, ack        run control; pause beats start, ack clears alarm
//   min/sec/milisec          remaining time
//   running                  high while counting
//   done                     one-cycle pulse on expiry
//   alarm                    level, set on expiry, cleared by ack or load
//
// Optional feature macro: AUTO_RELOAD_EN (reload from preset on expiry and keep
// running; a zero preset still expires normally).

module digital_countdown_timer #(
  parameter int TICK_DIV = 1,
  parameter int MAX_MIN  = 63
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  input  logic [9:0] set_ms,
  input  logic       start,
  input  logic       pause,
  input  logic       ack,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [9:0] milisec,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [5:0] MIN_CLAMP = 6'(MAX_MIN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_EXPIRED} state_t;

  state_t           state_q, state_d;
  logic [5:0]       min_q, min_d, sec_q, sec_d;
  logic [9:0]       ms_q, ms_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             done_q, done_d, alarm_q, alarm_d;

  logic [5:0]       ld_min, ld_sec, dec_min, dec_sec;
  logic [9:0]       ld_ms, dec_ms;
  logic             count_nz, dec_zero;

`ifdef AUTO_RELOAD_EN
  logic [5:0]       pmin_q, pmin_d, psec_q, psec_d;
  logic [9:0]       pms_q, pms_d;
  logic             preset_nz;
  assign preset_nz = (pmin_q != 6'd0) || (psec_q != 6'd0) || (pms_q != 10'd0);
`endif

  // Clamped load value.
  assign ld_min = (set_min > MIN_CLAMP) ? MIN_CLAMP : set_min;
  assign ld_sec = (set_sec > 6'd59) ? 6'd59 : set_sec;
  assign ld_ms  = (set_ms > 10'd999) ? 10'd999 : set_ms;

  assign count_nz = (min_q != 6'd0) || (sec_q != 6'd0) || (ms_q != 10'd0);

  // One-millisecond decrement with borrow through sec and min.
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    dec_ms  = ms_q;
    if (ms_q != 10'd0) begin
      dec_ms = ms_q - 10'd1;
    end else if (sec_q != 6'd0) begin
      dec_sec = sec_q - 6'd1;
      dec_ms  = 10'd999;
    end else begin
      dec_min = min_q - 6'd1;
      dec_sec = 6'd59;
      dec_ms  = 10'd999;
    end
  end

  assign dec_zero = (dec_min == 6'd0) && (dec_sec == 6'd0) && (dec_ms == 10'd0);

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ms_d    = ms_q;
    div_d   = div_q;
    done_d  = 1'b0;
    alarm_d = alarm_q;
`ifdef AUTO_RELOAD_EN
    pmin_d  = pmin_q;
    psec_d  = psec_q;
    pms_d   = pms_q;
`endif
    if (load && (state_q != S_RUN)) begin
      min_d   = ld_min;
      sec_d   = ld_sec;
      ms_d    = ld_ms;
`ifdef AUTO_RELOAD_EN
      pmin_d  = ld_min;
      psec_d  = ld_sec;
      pms_d   = ld_ms;
`endif
      div_d   = '0;
      alarm_d = 1'b0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Pause outranks start even here, so pause+start never launches.
          if (!pause && start && count_nz) state_d = S_RUN;
        end
        S_RUN: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else begin
            if (ack) alarm_d = 1'b0;
            if (div_q == DIV_LAST) begin
              div_d = '0;
              min_d = dec_min;
              sec_d = dec_sec;
              ms_d  = dec_ms;
              if (dec_zero) begin
                done_d  = 1'b1;
                alarm_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                if (preset_nz) begin
                  min_d = pmin_q;
                  sec_d = psec_q;
                  ms_d  = pms_q;
                end else begin
                  state_d = S_EXPIRED;
                end
`else
                state_d = S_EXPIRED;
`endif
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        S_PAUSED: begin
          if (!pause) begin
            if (start && count_nz) state_d = S_RUN;
            else if (ack)          alarm_d = 1'b0;
          end
        end
        S_EXPIRED: begin
          if (ack) begin
            alarm_d = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      ms_q    <= 10'd0;
      div_q   <= '0;
      done_q  <= 1'b0;
      alarm_q <= 1'b0;
`ifdef AUTO_RELOAD_EN
      pmin_q  <= 6'd0;
      psec_q  <= 6'd0;
      pms_q   <= 10'd0;
`endif
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ms_q    <= ms_d;
      div_q   <= div_d;
      done_q  <= done_d;
      alarm_q <= alarm_d;
`ifdef AUTO_RELOAD_EN
      pmin_q  <= pmin_d;
      psec_q  <= psec_d;
      pms_q   <= pms_d;
`endif
    end
  end

  assign min     = min_q;
  assign sec     = sec_q;
  assign milisec = ms_q;
  assign running = (state_q == S_RUN);
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_digital_countdown_timer.sv
// tb/tb_digital_countdown_timer.sv - self-checking bench for digital_countdown_timer

module tb_digital_countdown_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT, TICK_DIV=1
  logic       reset, load, start, pause, ack;
  logic [5:0] set_min, set_sec;
  logic [9:0] set_ms;
  logic [5:0] c_min, c_sec;
  logic [9:0] c_ms;
  logic       c_running, c_done, c_alarm;

  // Second DUT, TICK_DIV=4
  logic       r2_reset, r2_load, r2_start, r2_pause, r2_ack;
  logic [5:0] r2_set_min, r2_set_sec;
  logic [9:0] r2_set_ms;
  logic [5:0] r2_min, r2_sec;
  logic [9:0] r2_ms;
  logic       r2_running, r2_done, r2_alarm;

  digital_countdown_timer #(.TICK_DIV(1), .MAX_MIN(63)) dut (
    .clk(clk), .reset(reset), .load(load), .set_min(set_min), .set_sec(set_sec),
    .set_ms(set_ms), .start(start), .pause(pause), .ack(ack),
    .min(c_min), .sec(c_sec), .milisec(c_ms), .running(c_running),
    .done(c_done), .alarm(c_alarm)
  );

  digital_countdown_timer #(.TICK_DIV(4), .MAX_MIN(63)) dut4 (
    .clk(clk), .reset(r2_reset), .load(r2_load), .set_min(r2_set_min), .set_sec(r2_set_sec),
    .set_ms(r2_set_ms), .start(r2_start), .pause(r2_pause), .ack(r2_ack),
    .min(r2_min), .sec(r2_sec), .milisec(r2_ms), .running(r2_running),
    .done(r2_done), .alarm(r2_alarm)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: remaining time as a plain millisecond total.
  typedef enum {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mode_t;
  mode_t mode;
  int    rem;
  bit    m_done, m_alarm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("min",     32'(c_min),     32'(rem / 60000));
    chk("sec",     32'(c_sec),     32'((rem / 1000) % 60));
    chk("ms",      32'(c_ms),      32'(rem % 1000));
    chk("running", 32'(c_running), 32'(mode == M_RUN));
    chk("done",    32'(c_done),    32'(m_done));
    chk("alarm",   32'(c_alarm),   32'(m_alarm));
  endtask

  task automatic model_update(input bit l, input int sm, input int ss, input int sms,
                              input bit st, input bit p, input bit a);
    int cm, cs, cms;
    m_done = 1'b0;
    if (l && mode != M_RUN) begin
      cm  = (sm > 63) ? 63 : sm;
      cs  = (ss > 59) ? 59 : ss;
      cms = (sms > 999) ? 999 : sms;
      rem = cm * 60000 + cs * 1000 + cms;
      m_alarm = 1'b0;
      mode = M_IDLE;
    end else begin
      case (mode)
        M_IDLE:    if (!p && st && rem != 0) mode = M_RUN;
        M_RUN: begin
          if (p) mode = M_PAUSED;
          else begin
            rem = rem - 1;
            if (rem == 0) begin
              m_done = 1'b1;
              m_alarm = 1'b1;
              mode = M_EXPIRED;
            end
          end
        end
        M_PAUSED:  if (!p && st && rem != 0) mode = M_RUN;
        M_EXPIRED: if (a) begin m_alarm = 1'b0; mode = M_IDLE; end
        default:   mode = M_IDLE;
      endcase
    end
  endtask

  task automatic step(input bit l, input int sm, input int ss, input int sms,
                      input bit st, input bit p, input bit a);
    load = l; set_min = 6'(sm); set_sec = 6'(ss); set_ms = 10'(sms);
    start = st; pause = p; ack = a;
    @(posedge clk);
    model_update(l, sm & 63, ss & 63, sms & 1023, st, p, a);
    #1;
    check_model();
    load = 1'b0; start = 1'b0; pause = 1'b0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    mode = M_IDLE; rem = 0; m_done = 1'b0; m_alarm = 1'b0;
    #1;
    check_model();
    reset = 1'b1;
  endtask

  int first_done, ndone;
  bit rl;
  int rsm, rss, rsms;

  initial begin
    reset = 1'b0; load = 0; start = 0; pause = 0; ack = 0;
    set_min = 0; set_sec = 0; set_ms = 0;
    r2_reset = 1'b0; r2_load = 0; r2_start = 0; r2_pause = 0; r2_ack = 0;
    r2_set_min = 0; r2_set_sec = 0; r2_set_ms = 0;
    mode = M_IDLE; rem = 0; m_done = 0; m_alarm = 0;

    // Reset state
    do_reset();
    chk("reset_running", 32'(c_running), 32'd0);

    // Load with clamping (6/10-bit ports: max encodable out-of-range values)
    step(1, 2, 63, 1023, 0, 0, 0);
    chk("clamp_min", 32'(c_min), 32'd2);
    chk("clamp_sec", 32'(c_sec), 32'd59);
    chk("clamp_ms",  32'(c_ms),  32'd999);
    chk("clamp_running", 32'(c_running), 32'd0);

    // Zero start after reset: stays idle
    do_reset();
    step(0, 0, 0, 0, 1, 0, 0);
    idle(3);
    chk("zero_start_running", 32'(c_running), 32'd0);
    chk("zero_start_done", 32'(c_done), 32'd0);

    // Borrow chain: 01:00.000
    step(1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("borrow_min", 32'(c_min), 32'd0);
    chk("borrow_sec", 32'(c_sec), 32'd59);
    chk("borrow_ms",  32'(c_ms),  32'd999);
    first_done = -1; ndone = 0;
    for (int i = 2; i <= 60000; i++) begin
      step(0, 0, 0, 0, 0, 0, 0);
      if (c_done) begin ndone++; first_done = i; end
    end
    chk("borrow_done_cycle", 32'(first_done), 32'd60000);
    chk("borrow_done_count", 32'(ndone), 32'd1);
    chk("borrow_alarm", 32'(c_alarm), 32'd1);

    // Alarm holds without ack
    idle(20);
    chk("hold_alarm", 32'(c_alarm), 32'd1);
    chk("hold_done",  32'(c_done),  32'd0);
    step(0, 0, 0, 0, 0, 0, 1);
    chk("ack_alarm", 32'(c_alarm), 32'd0);
    chk("ack_ms", 32'(c_ms), 32'd0);

    // Pause priority at 00:00.500
    step(1, 0, 0, 600, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(100);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 1, 0);
    chk("pause_ms", 32'(c_ms), 32'd500);
    chk("pause_running", 32'(c_running), 32'd0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(499);
    chk("resume_not_done", 32'(c_done), 32'd0);
    idle(1);
    chk("resume_done", 32'(c_done), 32'd1);

    // Load ignored in RUN; load clears alarm after expiry
    step(1, 0, 0, 100, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(5);
    step(1, 5, 0, 0, 0, 0, 0);
    chk("run_load_min", 32'(c_min), 32'd0);
    chk("run_load_ms",  32'(c_ms),  32'd94);
    idle(94);
    chk("run_load_alarm", 32'(c_alarm), 32'd1);
    step(1, 0, 0, 7, 0, 0, 1);
    chk("load_clr_alarm", 32'(c_alarm), 32'd0);
    chk("load_clr_ms", 32'(c_ms), 32'd7);

    // Reset mid-run
    step(1, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    idle(10);
    do_reset();
    chk("midrun_reset_done", 32'(c_done), 32'd0);
    idle(2);

    // TICK_DIV=4: 00:00.003 expires after 12 RUN cycles
    @(posedge clk); #1;
    r2_reset = 1'b1;
    r2_load = 1'b1; r2_set_ms = 10'd3;
    @(posedge clk); #1;
    r2_load = 1'b0; r2_start = 1'b1;
    @(posedge clk); #1;
    r2_start = 1'b0;
    chk("div4_running", 32'(r2_running), 32'd1);
    chk("div4_start_ms", 32'(r2_ms), 32'd3);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 4) chk("div4_ms_at4", 32'(r2_ms), 32'd2);
      chk("div4_done", 32'(r2_done), (i == 12) ? 32'd1 : 32'd0);
    end
    chk("div4_final_ms", 32'(r2_ms), 32'd0);

    // Randomized control traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rl = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) begin
        rsm = int'($urandom_range(0, 63));
        rss = int'($urandom_range(0, 63));
        rsms = int'($urandom_range(0, 1023));
      end else begin
        rsm = 0; rss = 0;
        rsms = int'($urandom_range(0, 40));
      end
      step(rl, rsm, rss, rsms, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
